id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 149 ++++++++++++++
 tb/tb_id_ex_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
//------------------------------------------------------------------------------
// Module   : id_ex_reg
// Purpose  : ID/EX pipeline register with load-use hazard detection, one-cycle
//            stall/bubble insertion, branch flush, same-cycle write-back bypass
//            into the captured operands, and a saturating bubble counter.
// Ports    : i_clk, i_reset            clock, synchronous active-high reset
//            i_flush                   squash the instruction entering EX
//            i_*_id                    decoded ID-stage instruction fields
//            i_wb_*                    write-back port of the same cycle
//            o_*_ex                    registered EX-stage copies
//            o_stall_id                hold PC and IF/ID this cycle
//            o_bubble_cnt              number of load-use bubbles inserted
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_reg #(
  // Counter width; saturates at all-ones and is zero-extended onto
  // o_bubble_cnt. Must be in the range 1..32.
  parameter int CNT_W = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid_id,
  input  logic [31:0] i_pc_id,
  input  logic [31:0] i_instr_id,
  input  logic [31:0] i_rs1_data_id,
  input  logic [31:0] i_rs2_data_id,
  input  logic [31:0] i_imm_id,
  input  logic [4:0]  i_rs1_addr_id,
  input  logic [4:0]  i_rs2_addr_id,
  input  logic [4:0]  i_rd_addr_id,
  input  logic        i_rs1_used_id,
  input  logic        i_rs2_used_id,
  input  logic        i_rd_wren_id,
  input  logic        i_mem_rden_id,
  input  logic [15:0] i_ctrl_id,
  input  logic        i_wb_wren,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_valid_ex,
  output logic [31:0] o_pc_ex,
  output logic [31:0] o_instr_ex,
  output logic [31:0] o_rs1_data_ex,
  output logic [31:0] o_rs2_data_ex,
  output logic [31:0] o_imm_ex,
  output logic [4:0]  o_rs1_addr_ex,
  output logic [4:0]  o_rs2_addr_ex,
  output logic [4:0]  o_rd_addr_ex,
  output logic        o_rd_wren_ex,
  output logic        o_mem_rden_ex,
  output logic [15:0] o_ctrl_ex,
  output logic        o_stall_id,
  output logic [31:0] o_bubble_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        mem_rden;
    logic [15:0] ctrl;
  } ex_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             w_hazard;

  // Operand read with x0 forced to zero and a same-cycle write-back
  // overriding the (stale) register-file value.
  function automatic logic [31:0] f_operand(input logic [4:0]  addr,
                                             input logic [31:0] rf_data,
                                             input logic        wb_wren,
                                             input logic [4:0]  wb_addr,
                                             input logic [31:0] wb_data);
    if (addr == 5'd0)                      return 32'd0;
    else if (wb_wren && wb_addr == addr)   return wb_data;
    else                                   return rf_data;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    w_hazard = i_valid_id & ex_q.valid & ex_q.mem_rden & (ex_q.rd_addr != 5'd0) &
               ((i_rs1_used_id & (i_rs1_addr_id == ex_q.rd_addr)) |
                (i_rs2_used_id & (i_rs2_addr_id == ex_q.rd_addr)));
  end

  assign o_stall_id = w_hazard & ~i_flush & ~i_reset;

  // Priority: reset, flush bubble, hazard bubble, capture. Bubbles are the
  // all-zero EX record, which is also the default.
  always_comb begin
    ex_d         = '0;
    bubble_cnt_d = bubble_cnt_q;
    if (i_reset) begin
      bubble_cnt_d = '0;
    end else if (i_flush) begin
      // flush bubble: counter untouched
    end else if (w_hazard) begin
      if (bubble_cnt_q != C_CNT_MAX) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else begin
      ex_d.valid    = i_valid_id;
      ex_d.pc       = i_pc_id;
      ex_d.instr    = i_instr_id;
      ex_d.rs1_data = f_operand(i_rs1_addr_id, i_rs1_data_id, i_wb_wren, i_wb_rd_addr, i_wb_data);
      ex_d.rs2_data = f_operand(i_rs2_addr_id, i_rs2_data_id, i_wb_wren, i_wb_rd_addr, i_wb_data);
      ex_d.imm      = i_imm_id;
      ex_d.rs1_addr = i_rs1_addr_id;
      ex_d.rs2_addr = i_rs2_addr_id;
      ex_d.rd_addr  = i_rd_addr_id;
      // An invalid slot must never write rd or start a load.
      ex_d.rd_wren  = i_rd_wren_id & i_valid_id;
      ex_d.mem_rden = i_mem_rden_id & i_valid_id;
      ex_d.ctrl     = i_ctrl_id;
    end
  end

  always_ff @(posedge i_clk) begin
    ex_q         <= ex_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign o_valid_ex    = ex_q.valid;
  assign o_pc_ex       = ex_q.pc;
  assign o_instr_ex    = ex_q.instr;
  assign o_rs1_data_ex = ex_q.rs1_data;
  assign o_rs2_data_ex = ex_q.rs2_data;
  assign o_imm_ex      = ex_q.imm;
  assign o_rs1_addr_ex = ex_q.rs1_addr;
  assign o_rs2_addr_ex = ex_q.rs2_addr;
  assign o_rd_addr_ex  = ex_q.rd_addr;
  assign o_rd_wren_ex  = ex_q.rd_wren;
  assign o_mem_rden_ex = ex_q.mem_rden;
  assign o_ctrl_ex     = ex_q.ctrl;
  assign o_bubble_cnt  = 32'(bubble_cnt_q);

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_reg
// Purpose  : Self-checking bench for id_ex_reg. A vector table (plus a
//            hand-written saturation sequence) drives one ID-stage slot per
//            cycle; expected EX records are queued at drive time and popped
//            after the clock edge. A second instance with a 2-bit counter
//            exercises counter saturation in a handful of cycles.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, instr, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic        rdw, memr;
    logic [15:0] ctrl;
    logic [31:0] cnt;
  } ex_t;

  typedef struct {
    logic        rst, flush, valid;
    logic [31:0] pc, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rd;
    logic        u1, u2, rdw, memr;
    logic        wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        exp_stall;
    logic [31:0] exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, valid, u1, u2, rdw, memr, wbw;
  logic [31:0] pc, instr, rs1d, rs2d, imm, wbd;
  logic [4:0]  rs1a, rs2a, rd, wba;
  logic [15:0] ctrl;

  logic        o_valid, o_rdw, o_memr, o_stall;
  logic [31:0] o_pc, o_instr, o_rs1d, o_rs2d, o_imm, o_cnt;
  logic [4:0]  o_rs1a, o_rs2a, o_rd;
  logic [15:0] o_ctrl;

  logic        s_valid, s_rdw, s_memr, s_stall;
  logic [31:0] s_pc, s_instr, s_rs1d, s_rs2d, s_imm, s_cnt;
  logic [4:0]  s_rs1a, s_rs2a, s_rd;
  logic [15:0] s_ctrl;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid_id(valid),
    .i_pc_id(pc), .i_instr_id(instr), .i_rs1_data_id(rs1d), .i_rs2_data_id(rs2d),
    .i_imm_id(imm), .i_rs1_addr_id(rs1a), .i_rs2_addr_id(rs2a), .i_rd_addr_id(rd),
    .i_rs1_used_id(u1), .i_rs2_used_id(u2), .i_rd_wren_id(rdw), .i_mem_rden_id(memr),
    .i_ctrl_id(ctrl), .i_wb_wren(wbw), .i_wb_rd_addr(wba), .i_wb_data(wbd),
    .o_valid_ex(o_valid), .o_pc_ex(o_pc), .o_instr_ex(o_instr), .o_rs1_data_ex(o_rs1d),
    .o_rs2_data_ex(o_rs2d), .o_imm_ex(o_imm), .o_rs1_addr_ex(o_rs1a), .o_rs2_addr_ex(o_rs2a),
    .o_rd_addr_ex(o_rd), .o_rd_wren_ex(o_rdw), .o_mem_rden_ex(o_memr), .o_ctrl_ex(o_ctrl),
    .o_stall_id(o_stall), .o_bubble_cnt(o_cnt)
  );

  id_ex_reg #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid_id(valid),
    .i_pc_id(pc), .i_instr_id(instr), .i_rs1_data_id(rs1d), .i_rs2_data_id(rs2d),
    .i_imm_id(imm), .i_rs1_addr_id(rs1a), .i_rs2_addr_id(rs2a), .i_rd_addr_id(rd),
    .i_rs1_used_id(u1), .i_rs2_used_id(u2), .i_rd_wren_id(rdw), .i_mem_rden_id(memr),
    .i_ctrl_id(ctrl), .i_wb_wren(wbw), .i_wb_rd_addr(wba), .i_wb_data(wbd),
    .o_valid_ex(s_valid), .o_pc_ex(s_pc), .o_instr_ex(s_instr), .o_rs1_data_ex(s_rs1d),
    .o_rs2_data_ex(s_rs2d), .o_imm_ex(s_imm), .o_rs1_addr_ex(s_rs1a), .o_rs2_addr_ex(s_rs2a),
    .o_rd_addr_ex(s_rd), .o_rd_wren_ex(s_rdw), .o_mem_rden_ex(s_memr), .o_ctrl_ex(s_ctrl),
    .o_stall_id(s_stall), .o_bubble_cnt(s_cnt)
  );

  int   checks = 0;
  int   errors = 0;
  ex_t  m = '0;          // bench's view of the EX register
  logic [1:0] m_sat = '0; // bench's view of the 2-bit counter
  ex_t  sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic f, input logic v,
                              input logic [31:0] p,
                              input logic [4:0] a1, input logic [31:0] d1, input logic x1,
                              input logic [4:0] a2, input logic [31:0] d2, input logic x2,
                              input logic [4:0] rdd, input logic w, input logic ld,
                              input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                              input logic es, input logic [31:0] ec);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.pc = p;
    t.rs1a = a1; t.rs1d = d1; t.u1 = x1; t.rs2a = a2; t.rs2d = d2; t.u2 = x2;
    t.rd = rdd; t.rdw = w; t.memr = ld; t.wbw = ww; t.wba = wa; t.wbd = wd;
    t.exp_stall = es; t.exp_cnt = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] d,
                                       input logic ww, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (ww && wa == a) return wd;
    return d;
  endfunction

  task automatic apply(input vec_t t);
    ex_t  nx, got;
    logic haz;
    @(negedge clk);
    rst = t.rst; flush = t.flush; valid = t.valid; pc = t.pc;
    instr = t.pc ^ 32'hA5A5_0000; imm = t.pc + 32'd4; ctrl = t.pc[15:0] ^ 16'h0F0F;
    rs1a = t.rs1a; rs1d = t.rs1d; u1 = t.u1; rs2a = t.rs2a; rs2d = t.rs2d; u2 = t.u2;
    rd = t.rd; rdw = t.rdw; memr = t.memr; wbw = t.wbw; wba = t.wba; wbd = t.wbd;
    #1;
    check("stall", 256'(o_stall), 256'(t.exp_stall));
    // Expected next EX record
    haz = t.valid & m.valid & m.memr & (m.rd != 0) &
          ((t.u1 & (t.rs1a == m.rd)) | (t.u2 & (t.rs2a == m.rd)));
    nx = '0;
    nx.cnt = m.cnt;
    if (t.rst) begin
      nx.cnt = 0; m_sat = 0;
    end else if (t.flush) begin
    end else if (haz) begin
      if (m.cnt != 32'hFFFF_FFFF) nx.cnt = m.cnt + 1;
      if (m_sat != 2'b11) m_sat = m_sat + 1;
    end else begin
      nx.valid = t.valid; nx.pc = t.pc; nx.instr = instr; nx.imm = imm; nx.ctrl = ctrl;
      nx.rs1d = opnd(t.rs1a, t.rs1d, t.wbw, t.wba, t.wbd);
      nx.rs2d = opnd(t.rs2a, t.rs2d, t.wbw, t.wba, t.wbd);
      nx.rs1a = t.rs1a; nx.rs2a = t.rs2a; nx.rd = t.rd;
      nx.rdw = t.rdw & t.valid; nx.memr = t.memr & t.valid;
    end
    sb.push_back(nx);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      m = sb.pop_front();
      got = {o_valid, o_pc, o_instr, o_rs1d, o_rs2d, o_imm, o_rs1a, o_rs2a, o_rd,
             o_rdw, o_memr, o_ctrl, o_cnt};
      check("ex_record", 256'(got), 256'(m));
      check("bubble_cnt", 256'(o_cnt), 256'(t.exp_cnt));
      check("sat_cnt", 256'(s_cnt), 256'({30'd0, m_sat}));
    end
  endtask

  initial begin
    rst = 1; flush = 0; valid = 0; u1 = 0; u2 = 0; rdw = 0; memr = 0; wbw = 0;
    pc = 0; instr = 0; rs1d = 0; rs2d = 0; imm = 0; wbd = 0;
    rs1a = 0; rs2a = 0; rd = 0; wba = 0; ctrl = 0;
    @(posedge clk);
    //           rst f v  pc        a1 d1        u1 a2 d2        u2 rd w ld ww wa wd          stall cnt
    tbl.push_back(mk(1,0,1, 32'h0F0, 1, 32'h11,    1, 2, 32'h22,    1, 3, 1,1, 0, 0, 0,          0, 0)); // reset wins
    tbl.push_back(mk(0,0,1, 32'h100, 1, 32'h10,    1, 2, 32'h20,    1, 3, 1,0, 0, 0, 0,          0, 0)); // ADD x3,x1,x2
    tbl.push_back(mk(0,0,1, 32'h104, 1, 32'h10,    1, 0, 0,         0, 5, 1,1, 0, 0, 0,          0, 0)); // LW x5
    tbl.push_back(mk(0,0,1, 32'h108, 5, 32'h55,    1, 1, 32'h10,    1, 6, 1,0, 0, 0, 0,          1, 1)); // load-use
    tbl.push_back(mk(0,0,1, 32'h108, 5, 32'h55,    1, 1, 32'h10,    1, 6, 1,0, 0, 0, 0,          0, 1)); // held ADD enters
    tbl.push_back(mk(0,0,1, 32'h10C, 7, 32'hAAAA,  1, 0, 32'h5555,  1, 8, 1,0, 1, 7, 32'h1234,   0, 1)); // WB bypass
    tbl.push_back(mk(0,0,1, 32'h110, 0, 32'h77,    1, 8, 32'h88,    1, 9, 1,0, 1, 0, 32'h999,    0, 1)); // WB to x0
    tbl.push_back(mk(0,0,0, 32'h114, 2, 32'h3,     1, 3, 32'h4,     1, 4, 1,1, 0, 0, 0,          0, 1)); // invalid slot
    tbl.push_back(mk(0,0,1, 32'h120, 1, 32'h10,    1, 0, 0,         0, 9, 1,1, 0, 0, 0,          0, 1)); // LW x9
    tbl.push_back(mk(0,1,1, 32'h124, 4, 32'h44,    1, 9, 32'h99,    1,10, 1,0, 0, 0, 0,          0, 1)); // flush beats hazard
    tbl.push_back(mk(0,0,1, 32'h120, 1, 32'h10,    1, 0, 0,         0, 9, 1,1, 0, 0, 0,          0, 1)); // LW x9 again
    tbl.push_back(mk(0,0,1, 32'h128, 0, 32'h0,     0, 9, 32'h99,    1,10, 1,0, 1, 9, 32'h7777,   1, 2)); // hazard via rs2
    tbl.push_back(mk(0,0,1, 32'h128, 0, 32'h0,     0, 9, 32'h9999,  1,10, 1,0, 0, 0, 0,          0, 2)); // held, no WB now
    tbl.push_back(mk(0,0,1, 32'h130, 1, 32'h10,    1, 0, 0,         0, 0, 1,1, 0, 0, 0,          0, 2)); // LW x0
    tbl.push_back(mk(0,0,1, 32'h134, 0, 32'h5,     1, 0, 32'h6,     1,11, 1,0, 0, 0, 0,          0, 2)); // x0 never hazards
    tbl.push_back(mk(0,0,1, 32'h138, 1, 32'h10,    1, 0, 0,         0, 5, 1,1, 0, 0, 0,          0, 2)); // LW x5
    tbl.push_back(mk(0,0,1, 32'h13C, 5, 32'h55,    1, 1, 32'h10,    1, 6, 1,0, 0, 0, 0,          1, 3)); // hazard cnt 3
    tbl.push_back(mk(0,0,1, 32'h138, 1, 32'h10,    1, 0, 0,         0, 5, 1,1, 0, 0, 0,          0, 3)); // LW x5 into EX
    tbl.push_back(mk(1,0,1, 32'h13C, 5, 32'h55,    1, 1, 32'h10,    1, 6, 1,0, 0, 0, 0,          0, 0)); // reset mid-stall
    tbl.push_back(mk(0,0,1, 32'h13C, 5, 32'h55,    1, 1, 32'h10,    1, 6, 1,0, 0, 0, 0,          0, 0)); // EX empty, capture
    foreach (tbl[i]) apply(tbl[i]);

    // Self-dependent load LW x5,0(x5): alternates capture / hazard bubble,
    // driving both counters up; the 2-bit one must pin at 3.
    for (int i = 0; i < 10; i++)
      apply(mk(0,0,1, 32'h200, 5, 32'h50, 1, 0, 0, 0, 5, 1,1, 0, 0, 0,
               logic'(i % 2), 32'((i + 1) / 2)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
